// File: rtl/ex_cdb_arbiter_pkg.sv
// ex_cdb_arbiter_pkg
//   Shared types for the EX -> complete path.
//   ex_packet_t : one finished instruction leaving a functional unit.
//   fu_idx_t    : index of a functional-unit result port.
//   rr_next()   : round-robin successor of an index, modulo the port count.
package ex_cdb_arbiter_pkg;

    localparam int unsigned NumFuDefault = 4;
    localparam int unsigned DepthDefault = 2;
    localparam int unsigned TagW         = 7;
    localparam int unsigned XlenW        = 32;

    typedef struct packed {
        logic              valid;
        logic [TagW-1:0]   tag;
        logic [XlenW-1:0]  alu_result;
        logic [4:0]        dest_reg_idx;
        logic              take_branch;
        logic [XlenW-1:0]  npc;
    } ex_packet_t;

    typedef logic [$clog2(NumFuDefault)-1:0] fu_idx_t;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/ex_cdb_arbiter_skid_fifo.sv
// ex_skid_fifo
//   DEPTH-entry FIFO of ex_packet_t holding one functional unit's results.
//   Ports:
//     clock, reset_n : clock and asynchronous active-low reset
//     clear          : synchronous flush of pointers and count
//     enq, enq_data  : push request and data (ignored when full)
//     deq            : pop request (ignored when empty)
//     full, empty    : occupancy flags derived from the count
//     head           : oldest entry, valid only when !empty
module ex_skid_fifo
    import ex_cdb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = DepthDefault
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       enq,
    input  ex_packet_t enq_data,
    input  logic       deq,
    output logic       full,
    output logic       empty,
    output ex_packet_t head
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    ex_packet_t      mem_q [DEPTH];
    ex_packet_t      mem_d [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_enq, do_deq;

    assign full   = (count_q == CntW'(DEPTH));
    assign empty  = (count_q == '0);
    assign head   = mem_q[rd_ptr_q];
    assign do_enq = enq && !full;
    assign do_deq = deq && !empty;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_enq) begin
                mem_d[wr_ptr_q] = enq_data;
                wr_ptr_d        = wr_ptr_q + PtrW'(1);
            end
            if (do_deq) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            // Push and pop together leave the count alone.
            unique case ({do_enq, do_deq})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ex_cdb_arbiter.sv
// ex_cdb_arbiter
//   Buffers finished packets from NUM_FU functional units in per-unit FIFOs and
//   forwards one per cycle, chosen round-robin, through the registered ex_reg.
//   Ports:
//     clock, reset_n : clock and asynchronous active-low reset
//     squash         : synchronous flush of all FIFOs, rr pointer and ex_reg.valid
//     fu_packet      : per-unit result offers (.valid = offer)
//     fu_ready       : per-unit accept, high while that FIFO is not full
//     ex_reg         : registered winner for the complete stage
module ex_cdb_arbiter
    import ex_cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_FU = NumFuDefault,
    parameter int unsigned DEPTH  = DepthDefault
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              squash,
    input  ex_packet_t        fu_packet [NUM_FU],
    output logic [NUM_FU-1:0] fu_ready,
    output ex_packet_t        ex_reg
);

    localparam int unsigned IdxW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0] fifo_enq, fifo_deq, fifo_full, fifo_empty;
    ex_packet_t        fifo_head [NUM_FU];

    logic              grant_valid;
    logic [IdxW-1:0]   grant_idx;
    logic [IdxW-1:0]   cand_idx;
    logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
    ex_packet_t        ex_reg_q, ex_reg_d;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
        // Ready depends only on the count, so an offer to a full FIFO waits
        // even if that FIFO is being drained this cycle.
        assign fifo_enq[i] = fu_packet[i].valid && !fifo_full[i] && !squash;
        assign fifo_deq[i] = grant_valid && (grant_idx == IdxW'(i)) && !squash;

        ex_skid_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clock    (clock),
            .reset_n  (reset_n),
            .clear    (squash),
            .enq      (fifo_enq[i]),
            .enq_data (fu_packet[i]),
            .deq      (fifo_deq[i]),
            .full     (fifo_full[i]),
            .empty    (fifo_empty[i]),
            .head     (fifo_head[i])
        );
    end

    assign fu_ready = ~fifo_full;
    assign ex_reg   = ex_reg_q;

    // Scan from rr_ptr upward with wrap; first non-empty FIFO wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            cand_idx = IdxW'((32'(rr_ptr_q) + k) % NUM_FU);
            if (!grant_valid && !fifo_empty[cand_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        ex_reg_d = '0;
        if (squash) begin
            rr_ptr_d = '0;
        end else if (grant_valid) begin
            rr_ptr_d       = IdxW'(rr_next(32'(grant_idx), NUM_FU));
            ex_reg_d       = fifo_head[grant_idx];
            ex_reg_d.valid = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
            ex_reg_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            ex_reg_q <= ex_reg_d;
        end
    end

endmodule

// File: tb/tb_ex_cdb_arbiter.sv
// tb_ex_cdb_arbiter
//   Directed stimulus for ex_cdb_arbiter. Expected packets are queued as they
//   are offered, in the hand-derived output order; a monitor pops and compares
//   whenever ex_reg.valid is seen. Direct checks cover reset, ready and timing.
module tb_ex_cdb_arbiter;
    import ex_cdb_arbiter_pkg::*;

    localparam int unsigned NFU = 4;

    typedef struct {
        logic [TagW-1:0]  tag;
        logic [XlenW-1:0] res;
    } exp_t;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic           squash = 1'b0;
    ex_packet_t     fu_packet [NFU];
    logic [NFU-1:0] fu_ready;
    ex_packet_t     ex_reg;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    ex_cdb_arbiter #(
        .NUM_FU (NFU),
        .DEPTH  (2)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .squash    (squash),
        .fu_packet (fu_packet),
        .fu_ready  (fu_ready),
        .ex_reg    (ex_reg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic ex_packet_t mk(input int tag);
        ex_packet_t p;
        p              = '0;
        p.valid        = 1'b1;
        p.tag          = TagW'(tag);
        p.alu_result   = 32'h1000 + 32'(tag);
        p.dest_reg_idx = 5'(tag);
        return p;
    endfunction

    task automatic push(input int tag, input logic [31:0] res);
        exp_t e;
        e.tag = TagW'(tag);
        e.res = res;
        exp_q.push_back(e);
    endtask

    task automatic clear_offers();
        for (int i = 0; i < NFU; i++) fu_packet[i] = '0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard monitor
    always @(negedge clock) begin
        if (reset_n === 1'b1 && ex_reg.valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_packet: got tag %0d, expected no packet", ex_reg.tag);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_tag", 32'(ex_reg.tag), 32'(e.tag));
                check("sb_alu_result", ex_reg.alu_result, e.res);
            end
        end
    end

    int   s0, s1, samp, hi;
    logic a0, a1, saw_full;

    initial begin
        clear_offers();
        // Reset state
        #3;
        check("reset_ex_valid", 32'(ex_reg.valid), 32'd0);
        check("reset_fu_ready", 32'(fu_ready), 32'hF);
        #4 reset_n = 1'b1;
        step();

        // 1: reset mid-stream with three packets queued
        fu_packet[0] = mk(1);
        fu_packet[1] = mk(2);
        fu_packet[2] = mk(3);
        step();
        clear_offers();
        fu_packet[0] = mk(4);
        step();
        check("t1_pre_reset_valid", 32'(ex_reg.valid), 32'd1);
        check("t1_pre_reset_tag", 32'(ex_reg.tag), 32'd1);
        #1 reset_n = 1'b0;
        clear_offers();
        #1;
        check("t1_reset_ex_valid", 32'(ex_reg.valid), 32'd0);
        check("t1_reset_fu_ready", 32'(fu_ready), 32'hF);
        #1 reset_n = 1'b1;
        repeat (5) step();

        // 2: single packet latency
        fu_packet[0] = mk(5);
        fu_packet[0].alu_result = 32'h1234;
        push(5, 32'h1234);
        step();
        clear_offers();
        check("t2_valid_after_e1", 32'(ex_reg.valid), 32'd0);
        step();
        check("t2_valid_after_e2", 32'(ex_reg.valid), 32'd1);
        step();
        check("t2_valid_after_e3", 32'(ex_reg.valid), 32'd0);

        // Idle squash returns rr_ptr to 0
        squash = 1'b1;
        step();
        squash = 1'b0;
        check("sq_idle_valid", 32'(ex_reg.valid), 32'd0);

        // 3: all four FUs offer at once
        for (int i = 0; i < NFU; i++) begin
            fu_packet[i] = mk(10 + i);
            push(10 + i, 32'h1000 + 32'(10 + i));
        end
        step();
        clear_offers();
        for (int i = 0; i < NFU; i++) begin
            step();
            check("t3_burst_valid", 32'(ex_reg.valid), 32'd1);
        end
        step();
        check("t3_end_valid", 32'(ex_reg.valid), 32'd0);

        // 4: FU0 and FU1 stream together; grants alternate from FU0
        for (int i = 0; i < 4; i++) begin
            push(30 + i, 32'h1000 + 32'(30 + i));
            push(40 + i, 32'h1000 + 32'(40 + i));
        end
        s0 = 0; s1 = 0; samp = 0; hi = 0; saw_full = 1'b0;
        for (int c = 0; c < 20 && (s0 < 4 || s1 < 4); c++) begin
            fu_packet[0] = (s0 < 4) ? mk(30 + s0) : '0;
            fu_packet[1] = (s1 < 4) ? mk(40 + s1) : '0;
            a0 = (s0 < 4) && fu_ready[0];
            a1 = (s1 < 4) && fu_ready[1];
            if (s0 < 4) begin
                samp++;
                if (fu_ready[0]) hi++;
                else saw_full = 1'b1;
            end
            step();
            if (a0) s0++;
            if (a1) s1++;
        end
        clear_offers();
        check("t4_fu0_all_accepted", 32'(s0), 32'd4);
        check("t4_fu1_all_accepted", 32'(s1), 32'd4);
        check("t4_fu0_reached_full", 32'(saw_full), 32'd1);
        check("t4_fu0_ready_duty_ok", 32'(hi * 2 >= samp), 32'd1);
        repeat (6) step();

        // 5: FU2 streams alone; count holds at 1 via enq+deq together
        for (int i = 0; i < 3; i++) begin
            fu_packet[2] = mk(50 + i);
            push(50 + i, 32'h1000 + 32'(50 + i));
            check("t5_fu2_ready", 32'(fu_ready[2]), 32'd1);
            step();
            if (i > 0) check("t5_stream_valid", 32'(ex_reg.valid), 32'd1);
        end
        clear_offers();
        step();
        check("t5_last_valid", 32'(ex_reg.valid), 32'd1);
        step();
        check("t5_end_valid", 32'(ex_reg.valid), 32'd0);

        // 6: squash with five packets queued (rr_ptr is 3 here)
        for (int i = 0; i < NFU; i++) fu_packet[i] = mk(60 + i);
        push(63, 32'h1000 + 32'd63);
        step();
        clear_offers();
        fu_packet[0] = mk(64);
        fu_packet[1] = mk(65);
        step();
        clear_offers();
        check("t6_pre_squash_ready", 32'(fu_ready), 32'hC);
        squash = 1'b1;
        fu_packet[2] = mk(66);
        step();
        squash = 1'b0;
        clear_offers();
        check("t6_squash_valid", 32'(ex_reg.valid), 32'd0);
        check("t6_squash_ready", 32'(fu_ready), 32'hF);
        repeat (8) step();

        repeat (3) step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
